// File: rtl/pong_pkg.sv
// pong_pkg: game-state encoding, pixel colours and screen geometry
// shared by the pong renderer and its ball engine.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_MISS  = 2'd2
    } state_e;

    localparam logic [2:0] C_NONE   = 3'b000;
    localparam logic [2:0] C_BALL   = 3'b010;
    localparam logic [2:0] C_PADDLE = 3'b100;
    localparam logic [2:0] C_WALL   = 3'b001;
    localparam logic [2:0] C_FLASH  = 3'b101;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int H_LAST    = 767;

    localparam int CNT_W = 7;

endpackage

// File: rtl/pong_ball_engine.sv
// pong_ball_engine: per-frame ball motion, wall/paddle bounces and miss
// detection; the ball is parked at screen centre while serving.
module pong_ball_engine
    import pong_pkg::*;
#(
    parameter int BALL_SIZE  = 8,
    parameter int BALL_SPEED = 2,
    parameter int PADDLE_W   = 64,
    parameter int PADDLE_Y   = 460,
    parameter int WALL       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick_i,
    input  logic [9:0] paddle_x_i,
    input  state_e     state_i,
    output logic [9:0] ball_x_o,
    output logic [8:0] ball_y_o,
    output logic       miss_o
);

    localparam logic [10:0] BS = 11'(BALL_SIZE);
    localparam logic [10:0] SP = 11'(BALL_SPEED);
    localparam logic [10:0] PW = 11'(PADDLE_W);
    localparam logic [10:0] PY = 11'(PADDLE_Y);
    localparam logic [10:0] WL = 11'(WALL);
    localparam logic [10:0] HV = 11'(H_VISIBLE);
    localparam logic [10:0] VV = 11'(V_VISIBLE);

    localparam logic [9:0] X0    = 10'((H_VISIBLE - BALL_SIZE) / 2);
    localparam logic [8:0] Y0    = 9'((V_VISIBLE - BALL_SIZE) / 2);
    localparam logic [9:0] X_MIN = 10'(WALL);
    localparam logic [9:0] X_MAX = 10'(H_VISIBLE - WALL - BALL_SIZE);
    localparam logic [8:0] Y_MIN = 9'(WALL);
    localparam logic [8:0] Y_HIT = 9'(PADDLE_Y - BALL_SIZE);
    localparam logic [9:0] XS    = 10'(BALL_SPEED);
    localparam logic [8:0] YS    = 9'(BALL_SPEED);

    // direction flags: 1 = moving towards larger coordinate
    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic       dx_q, dx_d;
    logic       dy_q, dy_d;

    logic [10:0] x, y, px;
    logic        hit_l, hit_r, hit_t, hit_p, fall, step;

    assign x  = {1'b0, x_q};
    assign y  = {2'b0, y_q};
    assign px = {1'b0, paddle_x_i};

    assign hit_l = !dx_q && (x < WL + SP);
    assign hit_r = dx_q && (x + BS + SP > HV - WL);
    assign hit_t = !dy_q && (y < WL + SP);
    assign hit_p = dy_q && (y + BS <= PY) && (y + BS + SP >= PY)
                   && (x + BS > px) && (x < px + PW);
    assign fall  = dy_q && (y + BS + SP > VV);
    assign step  = frame_tick_i && (state_i == ST_PLAY);

    assign miss_o = step && fall;

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        dx_d = dx_q;
        dy_d = dy_q;
        if (state_i == ST_SERVE) begin
            x_d  = X0;
            y_d  = Y0;
            dx_d = 1'b1;
            dy_d = 1'b0;
        end else if (step && !fall) begin
            if (hit_l) begin
                x_d  = X_MIN;
                dx_d = 1'b1;
            end else if (hit_r) begin
                x_d  = X_MAX;
                dx_d = 1'b0;
            end else begin
                x_d = dx_q ? x_q + XS : x_q - XS;
            end
            if (hit_t) begin
                y_d  = Y_MIN;
                dy_d = 1'b1;
            end else if (hit_p) begin
                y_d  = Y_HIT;
                dy_d = 1'b0;
            end else begin
                y_d = dy_q ? y_q + YS : y_q - YS;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q  <= X0;
            y_q  <= Y0;
            dx_q <= 1'b1;
            dy_q <= 1'b0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    assign ball_x_o = x_q;
    assign ball_y_o = y_q;

endmodule

// File: rtl/pong_game_renderer.sv
// pong_game_renderer: serve/play/miss FSM, paddle and registered pixel colour.
// Define PONG_AUTO_SERVE_EN to launch the ball automatically from SERVE.
module pong_game_renderer
    import pong_pkg::*;
#(
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int PADDLE_W     = 64,
    parameter int PADDLE_H     = 8,
    parameter int PADDLE_Y     = 460,
    parameter int PADDLE_SPEED = 4,
    parameter int WALL         = 8,
    parameter int MISS_FRAMES  = 60,
    parameter int SERVE_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_ce,
    input  logic [9:0] CounterX,
    input  logic [8:0] CounterY,
    input  logic       inDisplayArea,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_serve,
    output logic       vga_r,
    output logic       vga_g,
    output logic       vga_b,
    output logic [3:0] misses,
    output logic [1:0] game_state
);

    localparam logic [9:0] PAD0    = 10'((H_VISIBLE - PADDLE_W) / 2);
    localparam logic [9:0] PAD_MIN = 10'(WALL);
    localparam logic [9:0] PAD_MAX = 10'(H_VISIBLE - WALL - PADDLE_W);
    localparam logic [9:0] PSTEP   = 10'(PADDLE_SPEED);

    localparam logic [CNT_W-1:0] MISS_LAST = CNT_W'(MISS_FRAMES - 1);

    localparam logic [10:0] BS = 11'(BALL_SIZE);
    localparam logic [10:0] PW = 11'(PADDLE_W);
    localparam logic [10:0] PH = 11'(PADDLE_H);
    localparam logic [10:0] PY = 11'(PADDLE_Y);
    localparam logic [10:0] WL = 11'(WALL);
    localparam logic [10:0] HV = 11'(H_VISIBLE);

    state_e           state_q, state_d;
    logic [3:0]       misses_q, misses_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       pad_q, pad_d;
    logic [2:0]       rgb_q, rgb_d;

    logic       frame_tick, launch, miss;
    logic [9:0] ball_x;
    logic [8:0] ball_y;

    assign frame_tick = pix_ce && (CounterX == 10'(H_LAST))
                        && (CounterY == 9'(V_VISIBLE - 1));

`ifdef PONG_AUTO_SERVE_EN
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    assign launch = btn_serve || (cnt_q == SERVE_LAST);
`else
    logic unused_serve_cfg;
    assign unused_serve_cfg = (SERVE_FRAMES == 0);
    assign launch = btn_serve;
`endif

    pong_ball_engine #(
        .BALL_SIZE  (BALL_SIZE),
        .BALL_SPEED (BALL_SPEED),
        .PADDLE_W   (PADDLE_W),
        .PADDLE_Y   (PADDLE_Y),
        .WALL       (WALL)
    ) u_ball (
        .clk          (clk),
        .reset        (reset),
        .frame_tick_i (frame_tick),
        .paddle_x_i   (pad_q),
        .state_i      (state_q),
        .ball_x_o     (ball_x),
        .ball_y_o     (ball_y),
        .miss_o       (miss)
    );

    always_comb begin
        state_d  = state_q;
        misses_d = misses_q;
        cnt_d    = cnt_q;
        if (frame_tick) begin
            cnt_d = cnt_q + 1'b1;
            unique case (state_q)
                ST_SERVE: if (launch) state_d = ST_PLAY;
                ST_PLAY: begin
                    if (miss) begin
                        state_d  = ST_MISS;
                        misses_d = misses_q + 1'b1;
                        cnt_d    = '0;
                    end
                end
                ST_MISS: begin
                    if (cnt_q == MISS_LAST) begin
                        state_d = ST_SERVE;
                        cnt_d   = '0;
                    end
                end
                default: state_d = ST_SERVE;
            endcase
        end
    end

    always_comb begin
        pad_d = pad_q;
        if (frame_tick && (btn_left ^ btn_right)) begin
            if (btn_left)
                pad_d = (pad_q < PAD_MIN + PSTEP) ? PAD_MIN : pad_q - PSTEP;
            else
                pad_d = (pad_q > PAD_MAX - PSTEP) ? PAD_MAX : pad_q + PSTEP;
        end
    end

    logic [10:0] cx, cy, bx, by, pxl;
    logic        on_ball, on_pad, on_wall;

    assign cx  = {1'b0, CounterX};
    assign cy  = {2'b0, CounterY};
    assign bx  = {1'b0, ball_x};
    assign by  = {2'b0, ball_y};
    assign pxl = {1'b0, pad_q};

    assign on_ball = (cx >= bx) && (cx < bx + BS) && (cy >= by) && (cy < by + BS);
    assign on_pad  = (cx >= pxl) && (cx < pxl + PW) && (cy >= PY) && (cy < PY + PH);
    assign on_wall = (cx < WL) || (cx >= HV - WL) || (cy < WL);

    always_comb begin
        rgb_d = rgb_q;
        if (pix_ce) begin
            if (!inDisplayArea)
                rgb_d = C_NONE;
            else if (on_ball)
                rgb_d = C_BALL;
            else if (on_pad)
                rgb_d = C_PADDLE;
            else if (on_wall)
                rgb_d = (state_q == ST_MISS && cnt_q[3]) ? C_FLASH : C_WALL;
            else
                rgb_d = C_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_SERVE;
            misses_q <= '0;
            cnt_q    <= '0;
            pad_q    <= PAD0;
            rgb_q    <= C_NONE;
        end else begin
            state_q  <= state_d;
            misses_q <= misses_d;
            cnt_q    <= cnt_d;
            pad_q    <= pad_d;
            rgb_q    <= rgb_d;
        end
    end

    assign {vga_r, vga_g, vga_b} = rgb_q;
    assign misses     = misses_q;
    assign game_state = state_q;

endmodule

// File: tb/tb_pong_game_renderer.sv
// tb_pong_game_renderer: randomized play against a frame-level game model,
// plus directed serve, paddle clamp, auto-serve and reset checks.
module tb_pong_game_renderer;

`ifdef PONG_AUTO_SERVE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_ce = 1'b0;
    logic [9:0] CounterX = '0;
    logic [8:0] CounterY = '0;
    logic       inDisplayArea = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_serve = 1'b0;
    logic       vga_r, vga_g, vga_b;
    logic [3:0] misses;
    logic [1:0] game_state;

    always #5 clk = ~clk;

    pong_game_renderer dut (
        .clk           (clk),
        .reset         (reset),
        .pix_ce        (pix_ce),
        .CounterX      (CounterX),
        .CounterY      (CounterY),
        .inDisplayArea (inDisplayArea),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_serve     (btn_serve),
        .vga_r         (vga_r),
        .vga_g         (vga_g),
        .vga_b         (vga_b),
        .misses        (misses),
        .game_state    (game_state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // frame-level game model: integer positions, signed directions
    int m_state, m_miss, m_cnt, m_bx, m_by, m_dx, m_dy, m_pad;

    function automatic void model_reset();
        m_state = 0; m_miss = 0; m_cnt = 0;
        m_bx = 316; m_by = 236; m_dx = 1; m_dy = -1;
        m_pad = 288;
    endfunction

    function automatic void model_frame(input bit l, input bit r, input bit s);
        int opad, nx, ny, ndx, ndy;
        opad = m_pad;
        if (l && !r) m_pad = (m_pad - 4 < 8) ? 8 : m_pad - 4;
        else if (r && !l) m_pad = (m_pad + 4 > 568) ? 568 : m_pad + 4;
        case (m_state)
            0: begin
                if (s || (AUTO && m_cnt == 119)) m_state = 1;
                else m_cnt++;
            end
            1: begin
                if (m_dy > 0 && m_by + 10 > 480) begin
                    m_miss = (m_miss + 1) % 16;
                    m_cnt = 0;
                    m_state = 2;
                end else begin
                    nx = m_bx + 2 * m_dx; ndx = m_dx;
                    if (m_dx < 0 && m_bx < 10) begin nx = 8; ndx = 1; end
                    else if (m_dx > 0 && m_bx + 10 > 632) begin nx = 624; ndx = -1; end
                    ny = m_by + 2 * m_dy; ndy = m_dy;
                    if (m_dy < 0 && m_by < 10) begin ny = 8; ndy = 1; end
                    else if (m_dy > 0 && m_by + 8 <= 460 && m_by + 10 >= 460
                             && m_bx + 8 > opad && m_bx < opad + 64) begin
                        ny = 452; ndy = -1;
                    end
                    m_bx = nx; m_by = ny; m_dx = ndx; m_dy = ndy;
                end
            end
            default: begin
                if (m_cnt == 59) begin
                    m_state = 0; m_cnt = 0;
                    m_bx = 316; m_by = 236; m_dx = 1; m_dy = -1;
                end else m_cnt++;
            end
        endcase
    endfunction

    function automatic logic [2:0] exp_rgb(input int x, input int y, input bit disp);
        if (!disp) return 3'b000;
        if (x >= m_bx && x < m_bx + 8 && y >= m_by && y < m_by + 8) return 3'b010;
        if (x >= m_pad && x < m_pad + 64 && y >= 460 && y < 468) return 3'b100;
        if (x < 8 || x >= 632 || y < 8)
            return (m_state == 2 && ((m_cnt >> 3) & 1) == 1) ? 3'b101 : 3'b001;
        return 3'b000;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; pix_ce = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic frame(input bit l, input bit r, input bit s);
        @(negedge clk);
        btn_left = l; btn_right = r; btn_serve = s;
        CounterX = 10'd767; CounterY = 9'd479; inDisplayArea = 1'b0; pix_ce = 1'b1;
        @(negedge clk);
        pix_ce = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_serve = 1'b0;
        model_frame(l, r, s);
        check("state", int'(game_state), m_state);
        check("misses", int'(misses), m_miss);
    endtask

    task automatic probe(input string tag, input int x, input int y,
                         input bit disp, input logic [2:0] exp);
        @(negedge clk);
        CounterX = 10'(x); CounterY = 9'(y); inDisplayArea = disp; pix_ce = 1'b1;
        @(negedge clk);
        pix_ce = 1'b0;
        check(tag, int'({vga_r, vga_g, vga_b}), int'(exp));
    endtask

    task automatic mprobe(input string tag, input int x, input int y, input bit disp);
        probe(tag, x, y, disp, exp_rgb(x, y, disp));
    endtask

    initial begin
        bit l, r, s;
        int hold, mode;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
        check("rst_state", int'(game_state), 0);
        check("rst_misses", int'(misses), 0);

        repeat (119) frame(1'b0, 1'b0, 1'b0);
        check("auto_pre", int'(game_state), 0);
        frame(1'b0, 1'b0, 1'b0);
        check("auto_120", int'(game_state), AUTO ? 1 : 0);

        do_reset();
        probe("px_ball", 320, 240, 1'b1, 3'b010);
        @(negedge clk);
        CounterX = 10'd0;
        @(negedge clk);
        check("rgb_hold", int'({vga_r, vga_g, vga_b}), 3'b010);
        probe("px_wall", 0, 100, 1'b1, 3'b001);
        probe("px_pad", 300, 465, 1'b1, 3'b100);
        probe("px_blank", 700, 100, 1'b0, 3'b000);

        repeat (100) frame(1'b1, 1'b0, 1'b0);
        probe("pad_min", 8, 460, 1'b1, 3'b100);
        probe("pad_min_w", 7, 460, 1'b1, 3'b001);
        probe("pad_min_r", 71, 467, 1'b1, 3'b100);
        probe("pad_min_o", 72, 460, 1'b1, 3'b000);
        repeat (5) frame(1'b1, 1'b1, 1'b0);
        probe("pad_both", 8, 460, 1'b1, 3'b100);
        frame(1'b0, 1'b1, 1'b0);
        probe("pad_right", 12, 460, 1'b1, 3'b100);
        probe("pad_right_o", 11, 460, 1'b1, 3'b000);

        frame(1'b0, 1'b0, 1'b1);
        check("serve_play", int'(game_state), 1);
        repeat (3) frame(1'b0, 1'b0, 1'b0);
        probe("ball3_tl", 322, 230, 1'b1, 3'b010);
        probe("ball3_l", 321, 230, 1'b1, 3'b000);
        probe("ball3_t", 322, 229, 1'b1, 3'b000);
        probe("ball3_br", 329, 237, 1'b1, 3'b010);
        probe("ball3_r", 330, 237, 1'b1, 3'b000);

        hold = 0; mode = 0;
        for (int f = 0; f < 1500; f++) begin
            if (hold == 0) begin
                hold = $urandom_range(1, 25);
                mode = $urandom_range(0, 5);
            end
            hold--;
            case (mode)
                0: begin l = 1'b1; r = 1'b0; end
                1: begin l = 1'b0; r = 1'b1; end
                2: begin l = 1'b1; r = 1'b1; end
                3: begin l = 1'b0; r = 1'b0; end
                default: begin
                    l = (m_pad + 32 > m_bx + 12);
                    r = (m_pad + 32 < m_bx - 4);
                end
            endcase
            s = ($urandom_range(0, 9) == 0);
            frame(l, r, s);
            mprobe("ball_tl", m_bx, m_by, 1'b1);
            mprobe("ball_br", m_bx + 7, m_by + 7, 1'b1);
            mprobe("ball_l", m_bx - 1, m_by + 3, 1'b1);
            mprobe("ball_r", m_bx + 8, m_by + 4, 1'b1);
            mprobe("pad_l", m_pad, 460, 1'b1);
            mprobe("pad_r", m_pad + 64, 467, 1'b1);
            mprobe("wall", $urandom_range(0, 7), $urandom_range(8, 479), 1'b1);
            mprobe("rand", $urandom_range(0, 639), $urandom_range(0, 479),
                   $urandom_range(0, 7) != 0);
        end

        probe("mid_ball", 8 + m_bx - m_bx + (m_bx - 8), m_by, 1'b1, 3'b010);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("mid_rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
        check("mid_rst_state", int'(game_state), 0);
        check("mid_rst_misses", int'(misses), 0);
        mprobe("post_rst", 320, 240, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
